fb_rect_fill: RTL and testbench

- Rectangle-fill pixel generator; sits directly upstream of the framebuffer writer.
- Accepts one fill command (two corners + colour) and emits every covered pixel as a linear framebuffer address + colour on a valid/ready stream, one pixel per cycle when unstalled.
- Normalises and clips corners to the framebuffer; computes addresses incrementally (row base + x).
- The downstream writer consumes the stream unchanged (addr, color, valid/ready).

---
 rtl/gfx_pkg.sv | 22 ++
 rtl/fb_rect_fill.sv | 155 +++++++++++++++
 tb/tb_fb_rect_fill.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the pixel-generator family (rect fill, line, blit).
package gfx_pkg;

  // Sequencer states common to the fill-style generators.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2
  } fill_state_e;

  // Default coordinate width for a 640x480-class framebuffer.
  localparam int COORD_BITS = 10;

  typedef logic [COORD_BITS-1:0] coord_t;

  // A screen-space point, used by the line and blit generators as well.
  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

endpackage

// File: rtl/fb_rect_fill.sv
// Rectangle-fill pixel generator: takes one fill command (two corners and a
// colour), normalises and clips it to the framebuffer, then streams every
// covered pixel in row-major order as a linear address plus colour.
module fb_rect_fill
  import gfx_pkg::*;
#(
  parameter int FB_WIDTH       = 640,
  parameter int FB_HEIGHT      = 480,
  parameter int PIXEL_BITS     = 12,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int X_BITS         = 10,
  parameter int Y_BITS         = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [X_BITS-1:0]         cmd_x0,
  input  logic [Y_BITS-1:0]         cmd_y0,
  input  logic [X_BITS-1:0]         cmd_x1,
  input  logic [Y_BITS-1:0]         cmd_y1,
  input  logic [PIXEL_BITS-1:0]     cmd_color,
  output logic                      pixel_valid,
  input  logic                      pixel_ready,
  output logic [AXI_ADDR_WIDTH-1:0] pixel_addr,
  output logic [PIXEL_BITS-1:0]     pixel_color,
  output logic                      busy,
  output logic                      done
);

  localparam logic [31:0]               FBW_U = 32'(FB_WIDTH);
  localparam logic [31:0]               FBH_U = 32'(FB_HEIGHT);
  localparam logic [AXI_ADDR_WIDTH-1:0] FBW_A = AXI_ADDR_WIDTH'(FB_WIDTH);
  localparam logic [X_BITS-1:0]         X_MAX = X_BITS'(FB_WIDTH - 1);
  localparam logic [Y_BITS-1:0]         Y_MAX = Y_BITS'(FB_HEIGHT - 1);

  fill_state_e state, next_state;

  // Raw corners as accepted; normalised during SETUP.
  logic [X_BITS-1:0] x0_q, x1_q;
  logic [Y_BITS-1:0] y0_q, y1_q;

  // Normalised, clipped bounds and the walking position.
  logic [X_BITS-1:0] xl_q, xr_q, x_q;
  logic [Y_BITS-1:0] yb_q, y_q;
  logic [AXI_ADDR_WIDTH-1:0] row_base_q;

  logic [X_BITS-1:0] xmin_c, xmax_c, xr_c;
  logic [Y_BITS-1:0] ymin_c, ymax_c, yb_c;
  logic [AXI_ADDR_WIDTH-1:0] row_base_c;
  logic empty_c;
  logic fire;
  logic x_more, y_more;

  // Corner normalisation, clipping and the first row base for SETUP.
  always_comb begin
    xmin_c     = (x0_q < x1_q) ? x0_q : x1_q;
    xmax_c     = (x0_q < x1_q) ? x1_q : x0_q;
    ymin_c     = (y0_q < y1_q) ? y0_q : y1_q;
    ymax_c     = (y0_q < y1_q) ? y1_q : y0_q;
    xr_c       = (32'(xmax_c) > FBW_U - 32'd1) ? X_MAX : xmax_c;
    yb_c       = (32'(ymax_c) > FBH_U - 32'd1) ? Y_MAX : ymax_c;
    empty_c    = (32'(xmin_c) >= FBW_U) || (32'(ymin_c) >= FBH_U);
    row_base_c = AXI_ADDR_WIDTH'(ymin_c) * FBW_A;
  end

  assign fire   = pixel_valid & pixel_ready;
  assign x_more = (x_q < xr_q);
  assign y_more = (y_q < yb_q);

  // State register; reset aborts any fill in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode plus the state-derived handshake/status outputs.
  always_comb begin
    next_state = state;
    cmd_ready  = (state == IDLE);
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (cmd_valid) next_state = SETUP;
      SETUP:   next_state = empty_c ? IDLE : FILL;
      FILL:    if (fire && !x_more && !y_more) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command capture, rectangle walk and registered pixel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      xl_q        <= '0;
      xr_q        <= '0;
      x_q         <= '0;
      yb_q        <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      pixel_valid <= 1'b0;
      pixel_addr  <= '0;
      pixel_color <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x0_q        <= cmd_x0;
            x1_q        <= cmd_x1;
            y0_q        <= cmd_y0;
            y1_q        <= cmd_y1;
            pixel_color <= cmd_color;
          end
        end
        SETUP: begin
          xl_q <= xmin_c;
          xr_q <= xr_c;
          yb_q <= yb_c;
          x_q  <= xmin_c;
          y_q  <= ymin_c;
          if (empty_c) begin
            done <= 1'b1;
          end else begin
            row_base_q  <= row_base_c;
            pixel_addr  <= row_base_c + AXI_ADDR_WIDTH'(xmin_c);
            pixel_valid <= 1'b1;
          end
        end
        FILL: begin
          if (fire) begin
            if (x_more) begin
              x_q        <= x_q + X_BITS'(1);
              pixel_addr <= pixel_addr + AXI_ADDR_WIDTH'(1);
            end else if (y_more) begin
              // Wrap to the left edge of the next row.
              x_q        <= xl_q;
              y_q        <= y_q + Y_BITS'(1);
              row_base_q <= row_base_q + FBW_A;
              pixel_addr <= row_base_q + FBW_A + AXI_ADDR_WIDTH'(xl_q);
            end else begin
              pixel_valid <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: expected addresses are queued when a
// command is issued and popped as the generator hands pixels over.
module tb_fb_rect_fill;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int PB = 12;
  localparam int AW = 20;
  localparam int XB = 10;
  localparam int YB = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [XB-1:0] cmd_x0, cmd_x1;
  logic [YB-1:0] cmd_y0, cmd_y1;
  logic [PB-1:0] cmd_color;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [AW-1:0] pixel_addr;
  logic [PB-1:0] pixel_color;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  fb_rect_fill #(
    .FB_WIDTH(W), .FB_HEIGHT(H), .PIXEL_BITS(PB),
    .AXI_ADDR_WIDTH(AW), .X_BITS(XB), .Y_BITS(YB)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_addr(pixel_addr), .pixel_color(pixel_color),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: row-major walk of the normalised, clipped rectangle.
  task automatic push_expected(input int x0, input int y0, input int x1, input int y1,
                               output int count);
    int xl, xr, yt, yb;
    xl = (x0 < x1) ? x0 : x1;
    xr = (x0 < x1) ? x1 : x0;
    yt = (y0 < y1) ? y0 : y1;
    yb = (y0 < y1) ? y1 : y0;
    if (xr > W - 1) xr = W - 1;
    if (yb > H - 1) yb = H - 1;
    count = 0;
    if (xl < W && yt < H) begin
      for (int y = yt; y <= yb; y++) begin
        for (int x = xl; x <= xr; x++) begin
          exp_q.push_back(AW'(y * W + x));
          count++;
        end
      end
    end
  endtask

  // Issue one command and drain its pixel stream against the model.
  task automatic test_fill(input string name, input int x0, input int y0,
                           input int x1, input int y1, input logic [PB-1:0] color,
                           input bit rand_ready, input bit hold_cmd);
    int n_exp;
    int last_hs;
    bit got_done;
    bit first_seen;
    bit stalled;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] a;
    last_hs = -10;
    got_done = 1'b0;
    first_seen = 1'b0;
    stalled = 1'b0;
    prev_addr = '0;
    exp_q.delete();
    push_expected(x0, y0, x1, y1, n_exp);

    @(negedge clk);
    cmd_x0 = XB'(x0); cmd_y0 = YB'(y0);
    cmd_x1 = XB'(x1); cmd_y1 = YB'(y1);
    cmd_color = color;
    cmd_valid = 1'b1;
    pixel_ready = 1'b1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_ready: got %b want 1", name, cmd_ready);
    end
    @(posedge clk);
    #1;
    if (hold_cmd) begin
      // Keep offering a different command while busy; it must be ignored.
      cmd_x0 = 10'd5; cmd_y0 = 10'd5; cmd_x1 = 10'd5; cmd_y1 = 10'd5;
      cmd_color = 12'h555;
    end else begin
      cmd_valid = 1'b0;
    end

    for (int n = 1; n <= 400 && !got_done; n++) begin
      @(negedge clk);
      pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == 1) begin
        n_vec++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s busy_setup: got busy=%b ready=%b want 1 0", name, busy, cmd_ready);
        end
      end
      if (stalled) begin
        n_vec++;
        if (pixel_valid !== 1'b1 || pixel_addr !== prev_addr) begin
          n_err++;
          $display("FAIL %s stall_hold: got v=%b addr=%0d want v=1 addr=%0d",
                   name, pixel_valid, pixel_addr, prev_addr);
        end
      end
      if (pixel_valid === 1'b1 && !first_seen) begin
        first_seen = 1'b1;
        n_vec++;
        if (n != 2) begin
          n_err++;
          $display("FAIL %s latency: got %0d want 2", name, n);
        end
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        n_vec++;
        if (n != ((n_exp == 0) ? 2 : last_hs + 1)) begin
          n_err++;
          $display("FAIL %s done_time: got cycle %0d want %0d", name, n,
                   (n_exp == 0) ? 2 : last_hs + 1);
        end
        n_vec++;
        if (exp_q.size() != 0 || cmd_ready !== 1'b1 || pixel_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s done_state: got left=%0d ready=%b v=%b want 0 1 0",
                   name, exp_q.size(), cmd_ready, pixel_valid);
        end
      end else if (pixel_valid === 1'b1) begin
        if (pixel_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s extra_pixel: got addr=%0d want none", name, pixel_addr);
          end else begin
            a = exp_q.pop_front();
            if (pixel_addr !== a || pixel_color !== color) begin
              n_err++;
              $display("FAIL %s pixel: got addr=%0d col=%h want addr=%0d col=%h",
                       name, pixel_addr, pixel_color, a, color);
            end
          end
          last_hs = n;
          if (exp_q.size() == 0) cmd_valid = 1'b0;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev_addr = pixel_addr;
        end
      end
    end
    cmd_valid = 1'b0;
    if (!got_done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s done_timeout: got no done want done", name);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || pixel_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: got done=%b v=%b busy=%b want 0 0 0",
               name, done, pixel_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    cmd_color = '0;
    pixel_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1 || pixel_valid !== 1'b0 || pixel_addr !== '0 ||
        pixel_color !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b v=%b a=%0d c=%h busy=%b done=%b want 1 0 0 0 0 0",
               cmd_ready, pixel_valid, pixel_addr, pixel_color, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    test_fill("basic", 1, 1, 2, 2, 12'hABC, 1'b0, 1'b0);
  endtask

  task automatic test_reversed();
    test_fill("reversed", 2, 2, 1, 1, 12'hABC, 1'b0, 1'b0);
  endtask

  task automatic test_clip();
    test_fill("clip", 638, 479, 700, 500, 12'h123, 1'b0, 1'b0);
  endtask

  task automatic test_empty();
    test_fill("empty", 650, 10, 660, 20, 12'hF0F, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    test_fill("stall", 0, 0, 3, 0, 12'h7E1, 1'b1, 1'b1);
    test_fill("stall_2row", 5, 7, 3, 8, 12'h0C3, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_fill("b2b_a", 637, 0, 639, 1, 12'h321, 1'b0, 1'b0);
    test_fill("b2b_b", 0, 478, 1, 479, 12'h654, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midfill();
    logic [AW-1:0] want;
    @(negedge clk);
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = 10'd9; cmd_y1 = 10'd9;
    cmd_color = 12'h9A5;
    cmd_valid = 1'b1;
    pixel_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      want = AW'(k);
      n_vec++;
      if (pixel_valid !== 1'b1 || pixel_addr !== want) begin
        n_err++;
        $display("FAIL midfill_pixel: got v=%b addr=%0d want v=1 addr=%0d",
                 pixel_valid, pixel_addr, want);
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (pixel_valid !== 1'b0 || pixel_addr !== '0 || pixel_color !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got v=%b a=%0d c=%h busy=%b done=%b rdy=%b want 0 0 0 0 0 1",
               pixel_valid, pixel_addr, pixel_color, busy, done, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || pixel_valid !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_quiet: got done=%b v=%b want 0 0", done, pixel_valid);
      end
    end
    test_fill("single", 0, 0, 0, 0, 12'h00F, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reversed();
    test_clip();
    test_empty();
    test_stall();
    test_back_to_back();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
